fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fq_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch widths, reset vector and fetch entry type
package riscv_pkg;

    localparam int WORD_BITWIDTH_DEF = 32;
    localparam logic [WORD_BITWIDTH_DEF-1:0] RESET_PC_DEF = 32'h0;

    typedef struct packed {
        logic [WORD_BITWIDTH_DEF-1:0] inst;
        logic [WORD_BITWIDTH_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - DEPTH-entry circular buffer with flush, full/empty/count
module fq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush beats any push or pop in the same cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with redirect discard; FETCH_QUEUE_BYPASS_EN adds same-cycle bypass
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = WORD_BITWIDTH_DEF,
    parameter int                       DEPTH         = 4,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_o,
    output logic [WORD_BITWIDTH-1:0] imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [WORD_BITWIDTH-1:0] imem_rdata_i,
    input  logic                     redirect_i,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc_i,
    output logic                     inst_valid_o,
    output logic [WORD_BITWIDTH-1:0] inst_o,
    output logic [WORD_BITWIDTH-1:0] pc_o,
    input  logic                     inst_ready_i
);

    localparam int W     = WORD_BITWIDTH;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W:0]   inflight;
    logic             grant, rsp_keep, bypass;
    logic             data_push, data_pop, data_empty, data_full;
    logic [CNT_W-1:0] data_count, pc_count;
    logic [2*W-1:0]   data_head;
    logic [W-1:0]     pc_head;
    logic             pc_full, pc_empty;
    logic             fifo_flags_unused;

    assign fifo_flags_unused = ^{pc_full, pc_empty, pc_count, data_full};

    // Queued plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign inflight    = {1'b0, data_count} + {1'b0, outstanding_q};
    assign imem_req_o  = rst && !redirect_i && (inflight < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign rsp_keep    = rst && imem_rvalid_i && !redirect_i && (discard_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_keep && data_empty;
`else
    assign bypass = 1'b0;
`endif

    assign data_push = rsp_keep && !(bypass && inst_ready_i);
    assign data_pop  = inst_ready_i && !redirect_i;

    fq_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (redirect_i),
        .push_i  (data_push),
        .data_i  ({imem_rdata_i, pc_head}),
        .pop_i   (data_pop),
        .data_o  (data_head),
        .full_o  (data_full),
        .empty_o (data_empty),
        .count_o (data_count)
    );

    // Addresses of live (non-discarded) requests, matched to responses in order.
    fq_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (redirect_i),
        .push_i  (grant),
        .data_i  (imem_addr_o),
        .pop_i   (rsp_keep),
        .data_o  (pc_head),
        .full_o  (pc_full),
        .empty_o (pc_empty),
        .count_o (pc_count)
    );

    always_comb begin
        inst_valid_o = !data_empty || bypass;
        inst_o       = '0;
        pc_o         = '0;
        if (!data_empty) begin
            inst_o = data_head[2*W-1:W];
            pc_o   = data_head[W-1:0];
        end else if (bypass) begin
            inst_o = imem_rdata_i;
            pc_o   = pc_head;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
        discard_d     = discard_q;
        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = {redirect_pc_i[W-1:2], 2'b00};
            discard_d  = outstanding_d;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + W'(4);
            end
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
`timescale 1ns/1ps
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         imem_req_o;
    logic [W-1:0] imem_addr_o;
    logic         imem_gnt_i;
    logic         imem_rvalid_i;
    logic [W-1:0] imem_rdata_i;
    logic         redirect_i;
    logic [W-1:0] redirect_pc_i;
    logic         inst_valid_o;
    logic [W-1:0] inst_o;
    logic [W-1:0] pc_o;
    logic         inst_ready_i;

    always #5 clk = ~clk;

    fetch_queue #(.WORD_BITWIDTH(W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    int           pass_cnt = 0;
    int           fail_cnt = 0;
    int           total_cnt = 0;
    logic [W-1:0] mem_q[$];
    fetch_entry_t sb_q[$];
    logic [W-1:0] cons_pc[$];
    int           discard_m;
    int           grants;
    logic [W-1:0] exp_pc;
    logic         gnt_en, resp_en, ready, redir;
    logic [W-1:0] redir_pc;
    logic         s_req, s_valid;

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        sb_q.delete();
        cons_pc.delete();
        discard_m = 0;
        grants    = 0;
        exp_pc    = 32'h0;
    endtask

    task automatic cycle();
        logic         resp;
        logic [W-1:0] a;
        fetch_entry_t e;
        resp = resp_en && (mem_q.size() > 0);
        a    = '0;
        if (resp) a = mem_q.pop_front();
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? inst_of(a) : '0;
        imem_gnt_i    = gnt_en;
        inst_ready_i  = ready;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        #1;
        s_req   = imem_req_o;
        s_valid = inst_valid_o;
        if (resp && !redir) begin
            if (discard_m > 0) begin
                discard_m--;
            end else begin
                e.inst = inst_of(a);
                e.pc   = a;
                sb_q.push_back(e);
            end
        end
        if (redir) begin
            check("req_low_on_redirect", {31'b0, imem_req_o}, 32'h0);
            sb_q.delete();
            discard_m = mem_q.size();
            exp_pc    = redir_pc;
        end else begin
            if (inst_valid_o && inst_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("stale_inst_valid", {31'b0, inst_valid_o}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("head_pc", pc_o, e.pc);
                    check("head_inst", inst_o, e.inst);
                    cons_pc.push_back(pc_o);
                end
            end
            if (imem_req_o && imem_gnt_i) begin
                check("fetch_addr", imem_addr_o, exp_pc);
                mem_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                grants++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        gnt_en  = 1'b0;
        resp_en = 1'b1;
        ready   = 1'b1;
        redir   = 1'b0;
        for (int i = 0; i < 30 && (mem_q.size() > 0 || sb_q.size() > 0 || inst_valid_o); i++) cycle();
        check("drained_valid", {31'b0, inst_valid_o}, 32'h0);
        check("drained_scoreboard", 32'(sb_q.size()), 32'h0);
        cons_pc.delete();
    endtask

    task automatic run_until_consumed(input int n);
        for (int i = 0; i < 40 && cons_pc.size() < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        gnt_en = 1'b0; resp_en = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);

        check("reset_req", {31'b0, imem_req_o}, 32'h0);
        check("reset_valid", {31'b0, inst_valid_o}, 32'h0);
        check("reset_inst", inst_o, 32'h0);
        check("reset_pc", pc_o, 32'h0);
        check("reset_addr", imem_addr_o, 32'h0);

        // Streaming from reset: pc 0,4,8,12.
        rst = 1'b1;
        gnt_en = 1'b1; resp_en = 1'b1; ready = 1'b1;
        cycle();
        check("first_req_after_reset", {31'b0, s_req}, 32'h1);
        run_until_consumed(4);
        for (int k = 0; k < 4; k++)
            check("burst_pc", (k < cons_pc.size()) ? cons_pc[k] : 32'hFFFF_FFFF, 32'(k * 4));

        // Asynchronous reset in the middle of the burst.
        cycle();
        cycle();
        #3 rst = 1'b0;
        #1;
        check("midreset_req", {31'b0, imem_req_o}, 32'h0);
        check("midreset_valid", {31'b0, inst_valid_o}, 32'h0);
        check("midreset_inst", inst_o, 32'h0);
        check("midreset_pc", pc_o, 32'h0);
        check("midreset_addr", imem_addr_o, 32'h0);
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; inst_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Decode stalled: queue fills after exactly DEPTH grants.
        gnt_en = 1'b1; resp_en = 1'b1; ready = 1'b0;
        repeat (10) cycle();
        check("stall_grants", 32'(grants), 32'd4);
        check("stall_req_low", {31'b0, s_req}, 32'h0);
        check("stall_valid", {31'b0, inst_valid_o}, 32'h1);
        check("stall_head_pc", pc_o, 32'h0);
        check("stall_head_inst", inst_o, inst_of(32'h0));
        drain();

        // Redirect with three fetches in flight.
        gnt_en = 1'b1; resp_en = 1'b0; ready = 1'b1;
        for (int i = 0; i < 10 && mem_q.size() < 3; i++) cycle();
        check("outstanding_before_redirect", 32'(mem_q.size()), 32'd3);
        redir = 1'b1; redir_pc = 32'h100;
        cycle();
        redir = 1'b0; resp_en = 1'b1;
        run_until_consumed(1);
        check("redirect_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hFFFF_FFFF, 32'h100);
        drain();

        // Redirect coincident with a response and a live gnt; queue holds an entry.
        gnt_en = 1'b1; resp_en = 1'b1; ready = 1'b0;
        cycle();
        cycle();
        resp_en = 1'b0;
        cycle();
        cycle();
        redir = 1'b1; redir_pc = 32'h200; resp_en = 1'b1; ready = 1'b1;
        cycle();
        redir = 1'b0;
        cycle();
        check("valid_after_redirect", {31'b0, s_valid}, 32'h0);
        run_until_consumed(1);
        check("redirect2_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hFFFF_FFFF, 32'h200);
        drain();

        // Back-to-back redirects; the second target wins.
        gnt_en = 1'b1; resp_en = 1'b0; ready = 1'b1;
        cycle();
        cycle();
        redir = 1'b1; redir_pc = 32'h300;
        cycle();
        redir_pc = 32'h400; resp_en = 1'b1;
        cycle();
        redir = 1'b0;
        run_until_consumed(1);
        check("b2b_redirect_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hFFFF_FFFF, 32'h400);
        drain();

        // Empty queue latency from response to inst_valid_o.
        ready = 1'b1; resp_en = 1'b1; gnt_en = 1'b1;
        cycle();
        gnt_en = 1'b0;
        cycle();
        check("valid_same_cycle", {31'b0, s_valid}, {31'b0, BYP});
        cycle();
        check("valid_next_cycle", {31'b0, s_valid}, {31'b0, ~BYP});
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
